// File: rtl/alu_vector_sequencer_pkg.sv
// Shared types for the ALU vector sequencer: ALU op codes and sequencer FSM states.
package alu_vector_sequencer_pkg;

   localparam int unsigned OpW = 2;

   typedef enum logic [OpW-1:0] {
      OpAdd = 2'b00,
      OpSub = 2'b01,
      OpAnd = 2'b10,
      OpOr  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StApply = 2'b01,
      StCheck = 2'b10,
      StDone  = 2'b11
   } state_e;

endpackage

// File: rtl/alu_vector_sequencer_if.sv
// Control, table-write, ALU and status signals of the sequencer.
// The master side is the sequencer; the slave side is the board, testbench or ALU.
interface alu_vector_sequencer_if #(
   parameter int unsigned Width = 8,
   parameter int unsigned AddrW = 2,
   parameter int unsigned ErrW  = 8
) ();
   import alu_vector_sequencer_pkg::*;

   logic             start;
   logic             loop_mode;
   logic             wr_en;
   logic [AddrW-1:0] wr_addr;
   logic [Width-1:0] wr_a;
   logic [Width-1:0] wr_b;
   logic [OpW-1:0]   wr_op;
   logic [Width-1:0] wr_exp_y;
   logic             wr_exp_c;
   logic [Width-1:0] alu_a;
   logic [Width-1:0] alu_b;
   logic [OpW-1:0]   alu_op;
   logic [Width-1:0] alu_y;
   logic             alu_carry;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ErrW-1:0]  err_cnt;
   logic [AddrW-1:0] cur_idx;
   logic             led;

   modport master (
      input  start, loop_mode, wr_en, wr_addr, wr_a, wr_b, wr_op, wr_exp_y, wr_exp_c,
      input  alu_y, alu_carry,
      output alu_a, alu_b, alu_op, busy, done, pass, err_cnt, cur_idx, led
   );

   modport slave (
      output start, loop_mode, wr_en, wr_addr, wr_a, wr_b, wr_op, wr_exp_y, wr_exp_c,
      output alu_y, alu_carry,
      input  alu_a, alu_b, alu_op, busy, done, pass, err_cnt, cur_idx, led
   );

endinterface

// File: rtl/alu_vector_sequencer_tick_gen.sv
// Clock-enable generator: one-cycle tick every DIV cycles of CLK100MHZ.
module alu_vector_sequencer_tick_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic CLK100MHZ,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) cnt_d = '0;
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LastCnt);

endmodule

// File: rtl/alu_vector_sequencer.sv
// Steps through a loadable table of ALU vectors at the tick rate, drives an external ALU
// and counts mismatches between its y/carry and the expected values.
module alu_vector_sequencer
   import alu_vector_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DIV   = 10,
   parameter int unsigned EW    = 8
) (
   input  logic                   CLK100MHZ,
   input  logic                   rst,
   alu_vector_sequencer_if.master bus
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned EntW = 3 * WIDTH + OpW + 1;
   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   logic             tick;
   state_e           state_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [OpW-1:0]   alu_op_q;
   logic             busy_q, done_q, pass_q, led_q;
   logic [EW-1:0]    err_q, err_nxt;
   logic [AW-1:0]    idx_q;

   logic [EntW-1:0]  tbl_q [DEPTH];
   logic [WIDTH-1:0] rd_a, rd_b, rd_y;
   logic [OpW-1:0]   rd_op;
   logic             rd_c;
   logic             mismatch;

   alu_vector_sequencer_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .CLK100MHZ (CLK100MHZ),
      .rst       (rst),
      .tick_o    (tick)
   );

   // Table contents survive reset so a board reset does not force a reload.
   always_ff @(posedge CLK100MHZ) begin
      if (bus.wr_en && !busy_q) begin
         tbl_q[bus.wr_addr] <= {bus.wr_a, bus.wr_b, bus.wr_op, bus.wr_exp_y, bus.wr_exp_c};
      end
   end

   assign {rd_a, rd_b, rd_op, rd_y, rd_c} = tbl_q[idx_q];

   always_comb begin
      mismatch = ({bus.alu_y, bus.alu_carry} != {rd_y, rd_c});
      err_nxt  = err_q;
      if (mismatch && (err_q != '1)) err_nxt = err_q + 1'b1;
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         led_q    <= 1'b0;
         err_q    <= '0;
         idx_q    <= '0;
      end else begin
         if (tick && busy_q) led_q <= ~led_q;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  err_q   <= '0;
                  idx_q   <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StApply;
               end
            end
            StApply: begin
               if (tick) begin
                  alu_a_q  <= rd_a;
                  alu_b_q  <= rd_b;
                  alu_op_q <= rd_op;
                  state_q  <= StCheck;
               end
            end
            StCheck: begin
               if (tick) begin
                  err_q <= err_nxt;
                  if (idx_q != LastIdx) begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= StApply;
                  end else if (bus.loop_mode) begin
                     idx_q   <= '0;
                     state_q <= StApply;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     // Includes a mismatch counted on this final check.
                     pass_q  <= (err_nxt == '0);
                     state_q <= StDone;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.alu_a   = alu_a_q;
   assign bus.alu_b   = alu_b_q;
   assign bus.alu_op  = alu_op_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.pass    = pass_q;
   assign bus.err_cnt = err_q;
   assign bus.cur_idx = idx_q;
   assign bus.led     = busy_q ? led_q : pass_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Scoreboard bench: two sequencers (EW=8 and EW=2) share stimulus, each drives its own ALU model.
module tb_alu_vector_sequencer;
   import alu_vector_sequencer_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DIV   = 4;
   localparam int unsigned AW    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             start, loop_mode, wr_en, wr_exp_c;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_a, wr_b, wr_exp_y;
   logic [1:0]       wr_op;

   alu_vector_sequencer_if #(.Width(WIDTH), .AddrW(AW), .ErrW(8)) bus8 ();
   alu_vector_sequencer_if #(.Width(WIDTH), .AddrW(AW), .ErrW(2)) bus2 ();

   function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a} - {1'b0, b};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   assign bus8.start = start;      assign bus2.start = start;
   assign bus8.loop_mode = loop_mode; assign bus2.loop_mode = loop_mode;
   assign bus8.wr_en = wr_en;      assign bus2.wr_en = wr_en;
   assign bus8.wr_addr = wr_addr;  assign bus2.wr_addr = wr_addr;
   assign bus8.wr_a = wr_a;        assign bus2.wr_a = wr_a;
   assign bus8.wr_b = wr_b;        assign bus2.wr_b = wr_b;
   assign bus8.wr_op = wr_op;      assign bus2.wr_op = wr_op;
   assign bus8.wr_exp_y = wr_exp_y; assign bus2.wr_exp_y = wr_exp_y;
   assign bus8.wr_exp_c = wr_exp_c; assign bus2.wr_exp_c = wr_exp_c;
   assign {bus8.alu_carry, bus8.alu_y} = ref_alu(bus8.alu_a, bus8.alu_b, bus8.alu_op);
   assign {bus2.alu_carry, bus2.alu_y} = ref_alu(bus2.alu_a, bus2.alu_b, bus2.alu_op);

   alu_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV), .EW(8)) dut8 (
      .CLK100MHZ (clk),
      .rst       (rst),
      .bus       (bus8)
   );

   alu_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV), .EW(2)) dut2 (
      .CLK100MHZ (clk),
      .rst       (rst),
      .bus       (bus2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Posedges since reset release; at a negedge it is the index of the next posedge.
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Reference table contents.
   logic [7:0] m_a [DEPTH];
   logic [7:0] m_b [DEPTH];
   logic [1:0] m_op [DEPTH];
   logic [7:0] m_y [DEPTH];
   logic       m_c [DEPTH];

   typedef struct {
      int         err8;
      int         err2;
      bit         pass;
      int         done_edge;
      logic [7:0] last_a;
   } exp_t;
   exp_t sb[$];

   logic done_prev;
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (bus8.done && !done_prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done rose at edge %0d with nothing expected",
                        cyc - 1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("err_cnt",       bus8.err_cnt, e.err8);
               check("err_cnt_ew2",   bus2.err_cnt, e.err2);
               check("pass",          bus8.pass,    e.pass);
               check("pass_ew2",      bus2.pass,    e.pass);
               check("led_at_done",   bus8.led,     e.pass);
               check("busy_at_done",  bus8.busy,    0);
               check("cur_idx_done",  bus8.cur_idx, DEPTH - 1);
               check("alu_a_held",    bus8.alu_a,   e.last_a);
               check("done_edge",     cyc - 1,      e.done_edge);
            end
         end
         done_prev = bus8.done;
      end
   end

   task automatic write_entry(input int idx, input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] op, input logic [7:0] y, input logic c);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(idx); wr_a = a; wr_b = b; wr_op = op;
      wr_exp_y = y; wr_exp_c = c;
      m_a[idx] = a; m_b[idx] = b; m_op[idx] = op; m_y[idx] = y; m_c[idx] = c;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   function automatic int first_tick_after(input int s);
      int t;
      t = s + 1;
      while ((t % DIV) != DIV - 1) t++;
      return t;
   endfunction

   task automatic do_run(input int passes, input bit disturb, input bit co_write);
      exp_t e;
      int   mism, err, s, t1, n, lim;
      logic [7:0] na, nb, ny;
      logic [1:0] nop;
      logic       nc;
      @(negedge clk);
      if (co_write) begin
         na = 8'($urandom); nb = 8'($urandom); nop = 2'($urandom);
         {nc, ny} = ref_alu(na, nb, nop);
         ny = ny ^ 8'($urandom_range(1));
         wr_en = 1'b1; wr_addr = 2'd1; wr_a = na; wr_b = nb; wr_op = nop;
         wr_exp_y = ny; wr_exp_c = nc;
         m_a[1] = na; m_b[1] = nb; m_op[1] = nop; m_y[1] = ny; m_c[1] = nc;
      end
      mism = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ref_alu(m_a[i], m_b[i], m_op[i]) != {m_c[i], m_y[i]}) mism++;
      end
      err = mism * passes;
      s = cyc;
      t1 = first_tick_after(s);
      e.err8 = (err > 255) ? 255 : err;
      e.err2 = (err > 3) ? 3 : err;
      e.pass = (err == 0);
      e.done_edge = t1 + (2 * DEPTH * passes - 1) * DIV;
      e.last_a = m_a[DEPTH-1];
      sb.push_back(e);
      loop_mode = (passes > 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (disturb) begin
         repeat (3) @(negedge clk);
         n = int'($urandom_range(DEPTH - 1));
         start = 1'b1; wr_en = 1'b1; wr_addr = AW'(n);
         wr_a = m_a[n]; wr_b = m_b[n]; wr_op = m_op[n];
         wr_exp_y = ~m_y[n]; wr_exp_c = m_c[n];
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
      end
      if (passes > 1) begin
         while (cyc <= t1 + 2 * DEPTH * (passes - 1) * DIV) @(negedge clk);
         loop_mode = 1'b0;
      end
      lim = (2 * DEPTH * passes + 4) * DIV;
      n = 0;
      while (!bus8.done && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (!bus8.done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done still 0 after %0d cycles, expected 1", lim);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int s, t1;
      logic [7:0] ra, rb, ry;
      logic [1:0] rop;
      logic       rc;
      start = 0; loop_mode = 0; wr_en = 0; wr_addr = 0; wr_a = 0; wr_b = 0;
      wr_op = 0; wr_exp_y = 0; wr_exp_c = 0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {bus8.busy, bus8.done, bus8.pass, bus8.err_cnt, bus8.cur_idx,
                              bus8.led, bus8.alu_a, bus8.alu_b, bus8.alu_op}, 0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("tick_phase", dut8.u_tick.tick_o, ((cyc % DIV) == DIV - 1) ? 1 : 0);
         @(negedge clk);
      end

      write_entry(0, 8'd3,   8'd5, OpAdd, 8'd8,  1'b0);
      write_entry(1, 8'd7,   8'd8, OpAdd, 8'd15, 1'b0);
      write_entry(2, 8'd15,  8'd1, OpAdd, 8'd16, 1'b0);
      write_entry(3, 8'd255, 8'd1, OpAdd, 8'd0,  1'b1);
      do_run(1, 0, 0);

      write_entry(2, 8'd15, 8'd1, OpAdd, 8'd17, 1'b0);
      do_run(1, 0, 0);
      do_run(3, 0, 0);
      do_run(5, 0, 0);

      do_run(1, 1, 0);
      do_run(1, 0, 0);
      do_run(1, 0, 1);

      // Abort a run while it sits in CHECK.
      @(negedge clk);
      start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
      t1 = first_tick_after(s);
      while (cyc <= t1 + 1) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy_done_pass", {bus8.busy, bus8.done, bus8.pass}, 0);
      check("abort_err_cnt", bus8.err_cnt, 0);
      check("abort_alu_a", bus8.alu_a, 0);
      check("abort_led", bus8.led, 0);
      @(negedge clk);
      rst = 1'b0;
      do_run(1, 0, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
            {rc, ry} = ref_alu(ra, rb, rop);
            if ($urandom_range(3) == 0) ry = ry ^ 8'($urandom_range(255, 1));
            if ($urandom_range(7) == 0) rc = ~rc;
            write_entry(i, ra, rb, rop, ry, rc);
         end
         do_run(int'($urandom_range(2, 1)), 0, 0);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
